// File: rtl/shift_in.sv
// shift_in: reader for a chain of 74HC165-style PISO registers.
// Ports: clk, rst_n, vld, busy, done, dout, sft_pl_n, sft_cp, sft_ce_n, sft_q7.
module shift_in #(
  parameter int NBITS    = 8,
  parameter int HALF     = 4,
  parameter int LOAD_CYC = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             vld,
  output logic             busy,
  output logic             done,
  output logic [NBITS-1:0] dout,
  output logic             sft_pl_n,
  output logic             sft_cp,
  output logic             sft_ce_n,
  input  logic             sft_q7
);

  localparam int PMAX =
    (HALF > LOAD_CYC) ? HALF : LOAD_CYC;
  localparam int PW =
    (PMAX > 1) ? $clog2(PMAX) : 1;
  localparam int BW =
    (NBITS > 1) ? $clog2(NBITS) : 1;

  localparam logic [4:0] S_IDLE = 5'b00001;
  localparam logic [4:0] S_LOAD = 5'b00010;
  localparam logic [4:0] S_LOW  = 5'b00100;
  localparam logic [4:0] S_HIGH = 5'b01000;
  localparam logic [4:0] S_DONE = 5'b10000;

  logic [4:0]       state;
  logic [4:0]       state_d;
  logic [PW-1:0]    ph;
  logic [PW-1:0]    ph_d;
  logic [BW-1:0]    bitc;
  logic [BW-1:0]    bit_d;
  logic [NBITS-1:0] shreg;
  logic [NBITS-1:0] shreg_d;
  logic [NBITS-1:0] dout_d;
  logic             q7_m;
  logic             q7_s;
  logic             ld_end;
  logic             hf_end;
  logic             bit_last;

  assign ld_end   = (ph == PW'(LOAD_CYC - 1));
  assign hf_end   = (ph == PW'(HALF - 1));
  assign bit_last = (bitc == BW'(NBITS - 1));

  // Q7 is driven from the chain's own
  // clock domain, so bring it in first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q7_m <= 1'b0;
      q7_s <= 1'b0;
    end else begin
      q7_m <= sft_q7;
      q7_s <= q7_m;
    end
  end

  always_comb begin
    state_d = state;
    ph_d    = ph;
    bit_d   = bitc;
    shreg_d = shreg;
    dout_d  = dout;
    unique case (1'b1)
      state[0]: begin
        if (vld) begin
          state_d = S_LOAD;
          ph_d    = '0;
        end
      end
      state[1]: begin
        if (ld_end) begin
          state_d = S_LOW;
          ph_d    = '0;
          bit_d   = '0;
        end else begin
          ph_d = ph + 1'b1;
        end
      end
      state[2]: begin
        if (hf_end) begin
          // Sample at the very end of the low
          // half, furthest from the last edge.
          shreg_d = {shreg[NBITS-2:0], q7_s};
          ph_d    = '0;
          if (bit_last) begin
            state_d = S_DONE;
            dout_d  = shreg_d;
          end else begin
            state_d = S_HIGH;
          end
        end else begin
          ph_d = ph + 1'b1;
        end
      end
      state[3]: begin
        if (hf_end) begin
          state_d = S_LOW;
          ph_d    = '0;
          bit_d   = bitc + 1'b1;
        end else begin
          ph_d = ph + 1'b1;
        end
      end
      state[4]: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        ph_d    = '0;
        bit_d   = '0;
      end
    endcase
  end

  // Chain controls follow the next state so
  // every pin comes straight from a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      ph       <= '0;
      bitc     <= '0;
      shreg    <= '0;
      dout     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sft_pl_n <= 1'b1;
      sft_cp   <= 1'b0;
      sft_ce_n <= 1'b1;
    end else begin
      state    <= state_d;
      ph       <= ph_d;
      bitc     <= bit_d;
      shreg    <= shreg_d;
      dout     <= dout_d;
      busy     <= (state_d != S_IDLE);
      done     <= (state_d == S_DONE);
      sft_pl_n <= (state_d != S_LOAD);
      sft_cp   <= (state_d == S_HIGH);
      sft_ce_n <= !((state_d == S_LOW) ||
                    (state_d == S_HIGH));
    end
  end

endmodule

// File: tb/tb_shift_in.sv
// tb_shift_in: directed bench for shift_in with
// behavioural 165 chains and a cycle model.
module tb_shift_in;

  localparam int AN = 8;
  localparam int AH = 4;
  localparam int AL = 4;
  localparam int AD = AL + (2*AN-1)*AH + 1;
  localparam int BN = 16;
  localparam int BH = 3;
  localparam int BL = 4;
  localparam int BD = BL + (2*BN-1)*BH + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic a_vld, b_vld;
  logic a_busy, a_done, a_pl_n, a_cp, a_ce_n, a_q7;
  logic b_busy, b_done, b_pl_n, b_cp, b_ce_n, b_q7;
  logic [AN-1:0] a_dout, a_par;
  logic [BN-1:0] b_dout, b_par;
  logic [AN-1:0] a_chain = '0;
  logic [BN-1:0] b_chain = '0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int a_cpe = 0;
  int b_cpe = 0;
  int a_pll = 0;
  int a_dq[$];
  int b_dq[$];
  logic [15:0] a_doq[$];
  logic [15:0] b_doq[$];

  shift_in #(.NBITS(AN), .HALF(AH), .LOAD_CYC(AL)) dut_a (
    .clk(clk), .rst_n(rst_n), .vld(a_vld),
    .busy(a_busy), .done(a_done), .dout(a_dout),
    .sft_pl_n(a_pl_n), .sft_cp(a_cp),
    .sft_ce_n(a_ce_n), .sft_q7(a_q7));

  shift_in #(.NBITS(BN), .HALF(BH), .LOAD_CYC(BL)) dut_b (
    .clk(clk), .rst_n(rst_n), .vld(b_vld),
    .busy(b_busy), .done(b_done), .dout(b_dout),
    .sft_pl_n(b_pl_n), .sft_cp(b_cp),
    .sft_ce_n(b_ce_n), .sft_q7(b_q7));

  always @(posedge clk) cyc <= cyc + 1;

  // 165 chains: async load while PL low,
  // shift toward Q7 on CP rise when enabled.
  always @(posedge a_cp or negedge a_pl_n)
    if (!a_pl_n) a_chain <= a_par;
    else if (!a_ce_n) a_chain <= a_chain << 1;
  always @(posedge b_cp or negedge b_pl_n)
    if (!b_pl_n) b_chain <= b_par;
    else if (!b_ce_n) b_chain <= b_chain << 1;
  assign a_q7 = a_chain[AN-1];
  assign b_q7 = b_chain[BN-1];

  always @(posedge a_cp) a_cpe <= a_cpe + 1;
  always @(posedge b_cp) b_cpe <= b_cpe + 1;

  // Transaction model: r counts cycles since
  // the accepting edge; r == D is the done cycle.
  bit a_act = 1'b0;
  bit b_act = 1'b0;
  int a_r = 0;
  int b_r = 0;
  logic [AN-1:0] a_word = '0, a_held = '0;
  logic [BN-1:0] b_word = '0, b_held = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_act <= 1'b0; a_r <= 0; a_held <= '0;
      b_act <= 1'b0; b_r <= 0; b_held <= '0;
    end else begin
      if (a_act) begin
        if (a_r == AD) begin
          a_act <= 1'b0; a_held <= a_word;
        end else a_r <= a_r + 1;
      end else if (a_vld) begin
        a_act <= 1'b1; a_r <= 1; a_word <= a_par;
      end
      if (b_act) begin
        if (b_r == BD) begin
          b_act <= 1'b0; b_held <= b_word;
        end else b_r <= b_r + 1;
      end else if (b_vld) begin
        b_act <= 1'b1; b_r <= 1; b_word <= b_par;
      end
    end
  end

  // {busy, done, pl_n, cp, ce_n}
  function automatic logic [4:0] exp_ctl(
    bit act, int r, int ld, int h, int d);
    logic sh;
    logic cp;
    sh = act && (r > ld) && (r < d);
    cp = sh && ((((r - ld - 1) / h) % 2) == 1);
    return {act, act && (r == d),
            !(act && (r <= ld)), cp, !sh};
  endfunction

  task automatic chk(string nm,
    logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t",
               nm, got, exp, $time);
    end
  endtask

  function automatic int qget(int q[$], int i);
    return (q.size() > i) ? q[i] : -1;
  endfunction

  function automatic logic [15:0] dget(
    logic [15:0] q[$], int i);
    return (q.size() > i) ? q[i] : 16'hDEAD;
  endfunction

  initial begin
    int c0, base, e0, p0, plf, plc;
    logic ce66, busy66;
    rst_n = 1'b0;
    a_vld = 1'b0; b_vld = 1'b0;
    a_par = '0; b_par = '0;
    ce66 = 1'b0; busy66 = 1'b1;
    fork
      forever begin
        @(negedge clk);
        chk("a_ctl",
          32'({a_busy, a_done, a_pl_n, a_cp, a_ce_n}),
          32'(exp_ctl(a_act, a_r, AL, AH, AD)));
        chk("a_dout", 32'(a_dout),
          32'((a_act && a_r == AD) ? a_word : a_held));
        chk("b_ctl",
          32'({b_busy, b_done, b_pl_n, b_cp, b_ce_n}),
          32'(exp_ctl(b_act, b_r, BL, BH, BD)));
        chk("b_dout", 32'(b_dout),
          32'((b_act && b_r == BD) ? b_word : b_held));
        if (a_done) begin
          a_dq.push_back(cyc);
          a_doq.push_back(16'(a_dout));
        end
        if (b_done) begin
          b_dq.push_back(cyc);
          b_doq.push_back(b_dout);
        end
        if (!a_pl_n) a_pll++;
      end
    join_none

    // 1: reset values, then quiet idle
    repeat (3) @(negedge clk);
    chk("rst_a_ctl",
      32'({a_busy, a_done, a_pl_n, a_cp, a_ce_n}),
      32'(5'b00101));
    chk("rst_a_dout", 32'(a_dout), 32'h0);
    chk("rst_b_ctl",
      32'({b_busy, b_done, b_pl_n, b_cp, b_ce_n}),
      32'(5'b00101));
    #1 rst_n = 1'b1;
    e0 = a_cpe; p0 = a_pll;
    repeat (100) @(negedge clk);
    chk("idle_cp_edges", 32'(a_cpe - e0), 32'd0);
    chk("idle_pl_low", 32'(a_pll - p0), 32'd0);

    // 2: single read of 8'hA5
    a_par = 8'hA5;
    base = a_dq.size(); e0 = a_cpe;
    plf = -1; plc = 0; c0 = 0;
    for (int rel = 0; rel < 80; rel++) begin
      @(negedge clk);
      if (rel == 0) c0 = cyc;
      if (!a_pl_n) begin
        if (plf < 0) plf = rel;
        plc++;
      end
      #1 a_vld = (rel == 0);
    end
    chk("t2_pl_first", 32'(plf), 32'd1);
    chk("t2_pl_cnt", 32'(plc), 32'd4);
    chk("t2_edges", 32'(a_cpe - e0), 32'd7);
    chk("t2_ndone", 32'(a_dq.size() - base), 32'd1);
    chk("t2_done_cyc", 32'(qget(a_dq, base) - c0), 32'd65);
    chk("t2_dout", 32'(dget(a_doq, base)), 32'hA5);

    // 3: pulses while busy are dropped
    a_par = 8'hA5;
    base = a_dq.size();
    for (int rel = 0; rel < 150; rel++) begin
      @(negedge clk);
      if (rel == 0) c0 = cyc;
      #1;
      a_vld = (rel == 0) || (rel == 10) ||
              (rel == 40) || (rel == 65) ||
              (rel == 70);
      if (rel == 10) a_par = 8'h3C;
    end
    a_vld = 1'b0;
    chk("t3_ndone", 32'(a_dq.size() - base), 32'd2);
    chk("t3_done0", 32'(qget(a_dq, base) - c0), 32'd65);
    chk("t3_done1", 32'(qget(a_dq, base + 1) - c0), 32'd135);
    chk("t3_dout0", 32'(dget(a_doq, base)), 32'hA5);
    chk("t3_dout1", 32'(dget(a_doq, base + 1)), 32'h3C);

    // 4: reset mid-shift aborts the read
    a_par = 8'hA5;
    base = a_dq.size();
    for (int rel = 0; rel < 120; rel++) begin
      @(negedge clk);
      if (rel == 0) c0 = cyc;
      #1;
      a_vld = (rel == 0) || (rel == 40);
      if (rel == 30) begin
        rst_n = 1'b0;
        #1;
        chk("t4_abort_ctl",
          32'({a_busy, a_done, a_pl_n, a_cp, a_ce_n}),
          32'(5'b00101));
        chk("t4_abort_dout", 32'(a_dout), 32'h0);
      end
      if (rel == 31) a_par = 8'hFF;
      if (rel == 33) rst_n = 1'b1;
    end
    a_vld = 1'b0;
    chk("t4_ndone", 32'(a_dq.size() - base), 32'd1);
    chk("t4_done_cyc", 32'(qget(a_dq, base) - c0), 32'd105);
    chk("t4_dout", 32'(dget(a_doq, base)), 32'hFF);

    // 5: two-chip chain, HALF=3
    b_par = 16'h1234;
    base = b_dq.size(); e0 = b_cpe;
    for (int rel = 0; rel < 110; rel++) begin
      @(negedge clk);
      if (rel == 0) c0 = cyc;
      #1 b_vld = (rel == 0);
    end
    b_vld = 1'b0;
    chk("t5_ndone", 32'(b_dq.size() - base), 32'd1);
    chk("t5_done_cyc", 32'(qget(b_dq, base) - c0), 32'd98);
    chk("t5_dout", 32'(dget(b_doq, base)), 32'h1234);
    chk("t5_edges", 32'(b_cpe - e0), 32'd15);

    // 6: vld held high -> back-to-back reads
    a_par = 8'h5A;
    base = a_dq.size();
    for (int rel = 0; rel < 150; rel++) begin
      @(negedge clk);
      if (rel == 0) c0 = cyc;
      if (rel == 66) begin
        ce66 = a_ce_n;
        busy66 = a_busy;
      end
      #1 a_vld = (rel <= 131);
    end
    a_vld = 1'b0;
    chk("t6_ndone", 32'(a_dq.size() - base), 32'd2);
    chk("t6_done0", 32'(qget(a_dq, base) - c0), 32'd65);
    chk("t6_done1", 32'(qget(a_dq, base + 1) - c0), 32'd131);
    chk("t6_dout1", 32'(dget(a_doq, base + 1)), 32'h5A);
    chk("t6_ce_gap", 32'(ce66), 32'd1);
    chk("t6_busy_gap", 32'(busy66), 32'd0);

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
